// File: rtl/iq_ctrl_pkg.sv
// Shared constants for the IQ sweep controller: default widths, FSM state codes
// and the averaging-depth clamp.
package iq_ctrl_pkg;

    localparam int DEF_PHASE_W  = 32;
    localparam int DEF_IQ_W     = 14;
    localparam int DEF_NPTS_W   = 12;
    localparam int DEF_SETTLE_W = 16;
    localparam int DEF_AVG_MAX  = 8;
    localparam int DEF_ACC_W    = DEF_IQ_W + DEF_AVG_MAX;

    localparam logic [1:0] ST_IDLE   = 2'd0;
    localparam logic [1:0] ST_SETTLE = 2'd1;
    localparam logic [1:0] ST_ACCUM  = 2'd2;
    localparam logic [1:0] ST_EMIT   = 2'd3;

    function automatic logic [3:0] clamp_log2(input logic [3:0] req, input int unsigned max_log2);
        return (32'(req) > max_log2) ? 4'(max_log2) : req;
    endfunction

endpackage

// File: rtl/iq_sweep_controller_if.sv
// Result stream from the sweep controller: one averaged I/Q word per sweep point.
interface iq_sweep_controller_if #(
    parameter int NPTS_W = iq_ctrl_pkg::DEF_NPTS_W,
    parameter int IQ_W   = iq_ctrl_pkg::DEF_IQ_W
);
    logic                     out_valid;
    logic                     out_ready;
    logic [NPTS_W-1:0]        out_index;
    logic signed [IQ_W-1:0]   out_I;
    logic signed [IQ_W-1:0]   out_Q;

    modport master (output out_valid, out_index, out_I, out_Q, input out_ready);
    modport slave  (input out_valid, out_index, out_I, out_Q, output out_ready);
endinterface

// File: rtl/iq_accumulator.sv
// I/Q sample accumulator: sums 2^sh filter-valid samples and presents the
// floor-rounded average.
module iq_accumulator
    import iq_ctrl_pkg::*;
#(
    parameter int IQ_W    = DEF_IQ_W,
    parameter int AVG_MAX = DEF_AVG_MAX
) (
    input  logic                   CLK,
    input  logic                   reset,
    input  logic                   clear,
    input  logic                   en,
    input  logic [3:0]             sh,
    input  logic signed [IQ_W-1:0] sample_i,
    input  logic signed [IQ_W-1:0] sample_q,
    output logic                   full,
    output logic signed [IQ_W-1:0] avg_i,
    output logic signed [IQ_W-1:0] avg_q
);
    localparam int ACC_WIDTH = IQ_W + AVG_MAX;
    localparam int CNT_W     = AVG_MAX + 1;

    logic signed [ACC_WIDTH-1:0] acc_i;
    logic signed [ACC_WIDTH-1:0] acc_q;
    logic [CNT_W-1:0]            cnt;
    logic [CNT_W-1:0]            target;

    assign target = CNT_W'(1) << sh;
    assign full   = (cnt == target);

    // Once full, further strobes are dropped so the sum stays exactly 2^sh samples.
    always_ff @(posedge CLK) begin
        if (reset || clear) begin
            acc_i <= '0;
            acc_q <= '0;
            cnt   <= '0;
        end else if (en && !full) begin
            acc_i <= acc_i + ACC_WIDTH'(sample_i);
            acc_q <= acc_q + ACC_WIDTH'(sample_q);
            cnt   <= cnt + CNT_W'(1);
        end
    end

    assign avg_i = IQ_W'(acc_i >>> sh);
    assign avg_q = IQ_W'(acc_q >>> sh);

endmodule

// File: rtl/iq_sweep_controller.sv
// Steps the NCO phase increment through a sweep, settling and averaging I/Q at
// each point and emitting one result word per point.
//
//   state  | meaning
//   IDLE   | waiting for start; config latched on start
//   SETTLE | pipeline flush after a tuning change, samples ignored
//   ACCUM  | accumulating filter-valid I/Q samples
//   EMIT   | result presented, waiting for out_ready
module iq_sweep_controller
    import iq_ctrl_pkg::*;
#(
    parameter int PHASE_W  = DEF_PHASE_W,
    parameter int IQ_W     = DEF_IQ_W,
    parameter int NPTS_W   = DEF_NPTS_W,
    parameter int SETTLE_W = DEF_SETTLE_W,
    parameter int AVG_MAX  = DEF_AVG_MAX
) (
    input  logic                   CLK,
    input  logic                   reset,
    input  logic                   start,
    input  logic                   abort,
    input  logic [PHASE_W-1:0]     startInc,
    input  logic [PHASE_W-1:0]     stepInc,
    input  logic [NPTS_W-1:0]      numPoints,
    input  logic [SETTLE_W-1:0]    settleCycles,
    input  logic [3:0]             avgLog2,
    input  logic                   filtValid,
    input  logic signed [IQ_W-1:0] I,
    input  logic signed [IQ_W-1:0] Q,
    output logic [PHASE_W-1:0]     phaseInc,
    output logic                   busy,
    output logic                   done,
    iq_sweep_controller_if.master  res
);
    logic [1:0]            state;
    logic [PHASE_W-1:0]    phase_r;
    logic [PHASE_W-1:0]    step_r;
    logic [NPTS_W-1:0]     npts_r;
    logic [NPTS_W-1:0]     index;
    logic [SETTLE_W-1:0]   settle_r;
    logic [SETTLE_W-1:0]   settle_cnt;
    logic [3:0]            sh_r;
    logic                  done_r;
    logic                  start_go;
    logic                  acc_clear;
    logic                  acc_en;
    logic                  acc_full;
    logic signed [IQ_W-1:0] avg_i;
    logic signed [IQ_W-1:0] avg_q;

    // abort outranks both a start in IDLE and a handshake in EMIT.
    assign start_go  = (state == ST_IDLE) && start && !abort;
    assign acc_clear = start_go || ((state == ST_EMIT) && res.out_ready && !abort);
    assign acc_en    = (state == ST_ACCUM) && filtValid;

    iq_accumulator #(.IQ_W(IQ_W), .AVG_MAX(AVG_MAX)) u_acc (
        .CLK      (CLK),
        .reset    (reset),
        .clear    (acc_clear),
        .en       (acc_en),
        .sh       (sh_r),
        .sample_i (I),
        .sample_q (Q),
        .full     (acc_full),
        .avg_i    (avg_i),
        .avg_q    (avg_q)
    );

    always_ff @(posedge CLK) begin
        if (reset) begin
            state         <= ST_IDLE;
            phase_r       <= '0;
            step_r        <= '0;
            npts_r        <= '0;
            index         <= '0;
            settle_r      <= '0;
            settle_cnt    <= '0;
            sh_r          <= '0;
            done_r        <= 1'b0;
            res.out_valid <= 1'b0;
            res.out_index <= '0;
            res.out_I     <= '0;
            res.out_Q     <= '0;
        end else begin
            done_r <= 1'b0;
            if (abort && (state != ST_IDLE)) begin
                state         <= ST_IDLE;
                res.out_valid <= 1'b0;
            end else begin
                case (state)
                    ST_IDLE: begin
                        if (start_go) begin
                            step_r   <= stepInc;
                            npts_r   <= numPoints;
                            settle_r <= settleCycles;
                            sh_r     <= clamp_log2(avgLog2, AVG_MAX);
                            index    <= '0;
                            if (numPoints == '0) begin
                                done_r <= 1'b1;
                            end else begin
                                phase_r    <= startInc;
                                settle_cnt <= settleCycles;
                                state      <= ST_SETTLE;
                            end
                        end
                    end
                    ST_SETTLE: begin
                        if (settle_cnt == '0) state <= ST_ACCUM;
                        else settle_cnt <= settle_cnt - SETTLE_W'(1);
                    end
                    ST_ACCUM: begin
                        if (acc_full) begin
                            res.out_valid <= 1'b1;
                            res.out_index <= index;
                            res.out_I     <= avg_i;
                            res.out_Q     <= avg_q;
                            state         <= ST_EMIT;
                        end
                    end
                    ST_EMIT: begin
                        if (res.out_ready) begin
                            res.out_valid <= 1'b0;
                            if (index == npts_r - NPTS_W'(1)) begin
                                done_r <= 1'b1;
                                state  <= ST_IDLE;
                            end else begin
                                index      <= index + NPTS_W'(1);
                                phase_r    <= phase_r + step_r;
                                settle_cnt <= settle_r;
                                state      <= ST_SETTLE;
                            end
                        end
                    end
                    default: state <= ST_IDLE;
                endcase
            end
        end
    end

    assign phaseInc = phase_r;
    assign busy     = (state != ST_IDLE);
    assign done     = done_r;

endmodule

// File: tb/tb_iq_sweep_controller.sv
// Scoreboard bench for iq_sweep_controller: directed sweeps push expected
// results, a negedge monitor pops and compares on every handshake.
module tb_iq_sweep_controller;
    import iq_ctrl_pkg::*;

    localparam int PW = 32;
    localparam int IW = 14;
    localparam int NW = 12;
    localparam int SW = 16;

    logic                 CLK = 1'b0;
    logic                 reset, start, abort, filtValid;
    logic [PW-1:0]        startInc, stepInc;
    logic [NW-1:0]        numPoints;
    logic [SW-1:0]        settleCycles;
    logic [3:0]           avgLog2;
    logic signed [IW-1:0] I, Q;
    logic [PW-1:0]        phaseInc;
    logic                 busy, done;

    iq_sweep_controller_if #(.NPTS_W(NW), .IQ_W(IW)) res();

    iq_sweep_controller #(.PHASE_W(PW), .IQ_W(IW), .NPTS_W(NW), .SETTLE_W(SW), .AVG_MAX(8)) dut (
        .CLK(CLK), .reset(reset), .start(start), .abort(abort),
        .startInc(startInc), .stepInc(stepInc), .numPoints(numPoints),
        .settleCycles(settleCycles), .avgLog2(avgLog2), .filtValid(filtValid),
        .I(I), .Q(Q), .phaseInc(phaseInc), .busy(busy), .done(done), .res(res)
    );

    always #5 CLK = ~CLK;

    typedef struct {
        logic [NW-1:0]        idx;
        logic signed [IW-1:0] i;
        logic signed [IW-1:0] q;
        logic [PW-1:0]        ph;
    } exp_t;

    exp_t sb[$];
    exp_t mon_e;
    int checks = 0, errors = 0;
    int cyc = 0, hs_cnt = 0, done_cnt = 0, last_hs_cyc = 0, last_done_cyc = 0;

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    always @(posedge CLK) cyc++;

    // Monitor: count done pulses and score every accepted result.
    always @(negedge CLK) begin
        if (done === 1'b1) begin
            done_cnt++;
            last_done_cyc = cyc;
        end
        if (res.out_valid === 1'b1 && res.out_ready === 1'b1) begin
            hs_cnt++;
            last_hs_cyc = cyc;
            if (sb.size() == 0) begin
                checks++;
                errors++;
                $display("FAIL sb_unexpected: result index %0d with nothing expected", res.out_index);
            end else begin
                mon_e = sb.pop_front();
                check("res_index", res.out_index, mon_e.idx);
                check("res_I", res.out_I, mon_e.i);
                check("res_Q", res.out_Q, mon_e.q);
                check("res_phase", phaseInc, mon_e.ph);
            end
        end
    end

    // Sample source: mode 0 = constant valid samples, mode 1 = table every 3rd cycle.
    int mode = 0;
    int k = 0, t = 0;
    logic signed [IW-1:0] ci, cq;
    logic signed [IW-1:0] tab_i [4] = '{14'sd1, 14'sd2, 14'sd3, 14'sd6};
    logic signed [IW-1:0] tab_q [4] = '{-14'sd1, -14'sd1, -14'sd1, -14'sd2};

    always @(posedge CLK) begin
        #1;
        if (mode == 0) begin
            filtValid = 1'b1;
            I = ci;
            Q = cq;
        end else begin
            k = (k + 1) % 3;
            if (k == 0) begin
                filtValid = 1'b1;
                I = tab_i[t];
                Q = tab_q[t];
                t = (t + 1) % 4;
            end else begin
                filtValid = 1'b0;
            end
        end
    end

    task automatic tick();
        @(posedge CLK);
        #1;
    endtask

    task automatic go(input logic [PW-1:0] s0, input logic [PW-1:0] st, input logic [NW-1:0] n,
                      input logic [SW-1:0] se, input logic [3:0] a,
                      input logic signed [IW-1:0] ei, input logic signed [IW-1:0] eq, input int npush);
        exp_t e;
        for (int p = 0; p < npush; p++) begin
            e.idx = NW'(p);
            e.i   = ei;
            e.q   = eq;
            e.ph  = s0 + st * PW'(p);
            sb.push_back(e);
        end
        startInc = s0; stepInc = st; numPoints = n; settleCycles = se; avgLog2 = a;
        start = 1'b1;
        tick();
        start = 1'b0;
    endtask

    task automatic wait_idle(input string name, input int budget);
        int n = 0;
        do begin
            @(negedge CLK);
            n++;
        end while (busy && n < budget);
        if (busy) begin
            checks++;
            errors++;
            $display("FAIL %s_timeout: busy still %0b after %0d cycles", name, busy, budget);
        end
    endtask

    task automatic wait_hs(input string name, input int target, input int budget);
        int n = 0;
        while (hs_cnt < target && n < budget) begin
            @(negedge CLK);
            n++;
        end
        if (hs_cnt < target) begin
            checks++;
            errors++;
            $display("FAIL %s_timeout: handshakes %0d expected %0d", name, hs_cnt, target);
        end
    endtask

    task automatic check_reset_outputs(input string tag);
        check({tag, "_phase"}, phaseInc, 0);
        check({tag, "_busy"}, busy, 0);
        check({tag, "_done"}, done, 0);
        check({tag, "_valid"}, res.out_valid, 0);
        check({tag, "_index"}, res.out_index, 0);
        check({tag, "_I"}, res.out_I, 0);
        check({tag, "_Q"}, res.out_Q, 0);
    endtask

    initial begin
        #500000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1);
    end

    initial begin
        int d0, h0, n;
        reset = 1'b1; start = 1'b0; abort = 1'b0; res.out_ready = 1'b1;
        startInc = '0; stepInc = '0; numPoints = '0; settleCycles = '0; avgLog2 = '0;
        filtValid = 1'b0; I = '0; Q = '0; ci = '0; cq = '0;
        repeat (3) tick();
        @(negedge CLK);
        check_reset_outputs("rst0");
        tick();
        reset = 1'b0;
        tick();

        // basic 3-point sweep, no averaging
        ci = 14'sd100; cq = -14'sd50;
        d0 = done_cnt; h0 = hs_cnt;
        go(32'h01000000, 32'h00100000, 3, 4, 0, 14'sd100, -14'sd50, 3);
        wait_idle("t1", 2000);
        tick(); tick();
        check("t1_done_cnt", done_cnt - d0, 1);
        check("t1_hs_cnt", hs_cnt - h0, 3);
        check("t1_done_timing", last_done_cyc - last_hs_cyc, 1);
        check("t1_sb_empty", sb.size(), 0);
        check("t1_phase_final", phaseInc, 32'h01200000);

        // 4-sample average of sparse samples, floor on negative Q
        mode = 1;
        d0 = done_cnt;
        go(32'h00000000, 32'h00000001, 2, 2, 2, 14'sd3, -14'sd2, 2);
        wait_idle("t2", 2000);
        tick();
        mode = 0;
        tick();
        check("t2_done_cnt", done_cnt - d0, 1);
        check("t2_sb_empty", sb.size(), 0);

        // back-pressure for 20 cycles in EMIT
        res.out_ready = 1'b0;
        ci = 14'sd7; cq = -14'sd7;
        d0 = done_cnt;
        go(32'h00400000, 32'h00010000, 2, 1, 1, 14'sd7, -14'sd7, 2);
        n = 0;
        do begin
            @(negedge CLK);
            n++;
        end while (res.out_valid !== 1'b1 && n < 500);
        check("t3_valid_seen", res.out_valid, 1);
        repeat (20) begin
            @(negedge CLK);
            check("t3_hold_valid", res.out_valid, 1);
            check("t3_hold_I", res.out_I, 14'sd7);
            check("t3_hold_Q", res.out_Q, -14'sd7);
            check("t3_hold_index", res.out_index, 0);
            check("t3_hold_phase", phaseInc, 32'h00400000);
        end
        tick();
        res.out_ready = 1'b1;
        wait_idle("t3", 2000);
        tick(); tick();
        check("t3_done_cnt", done_cnt - d0, 1);
        check("t3_sb_empty", sb.size(), 0);
        check("t3_phase_final", phaseInc, 32'h00410000);

        // phase wrap
        ci = 14'sd1; cq = 14'sd2;
        go(32'hFFF00000, 32'h00200000, 2, 0, 0, 14'sd1, 14'sd2, 2);
        wait_idle("t4", 2000);
        tick(); tick();
        check("t4_phase_wrap", phaseInc, 32'h00100000);
        check("t4_sb_empty", sb.size(), 0);

        // abort during ACCUM of point 1, then a clean sweep
        ci = 14'sd4; cq = -14'sd4;
        d0 = done_cnt; h0 = hs_cnt;
        go(32'h02000000, 32'h00080000, 3, 3, 3, 14'sd4, -14'sd4, 1);
        wait_hs("t5", h0 + 1, 2000);
        tick();
        repeat (6) tick();
        abort = 1'b1;
        tick();
        abort = 1'b0;
        @(negedge CLK);
        check("t5_abort_busy", busy, 0);
        check("t5_abort_valid", res.out_valid, 0);
        tick(); tick(); tick();
        check("t5_no_done", done_cnt - d0, 0);
        check("t5_hs_cnt", hs_cnt - h0, 1);
        check("t5_phase_hold", phaseInc, 32'h02080000);
        check("t5_sb_empty", sb.size(), 0);
        ci = -14'sd3; cq = 14'sd5;
        d0 = done_cnt;
        go(32'h00001000, 32'h00001000, 2, 1, 1, -14'sd3, 14'sd5, 2);
        wait_idle("t5b", 2000);
        tick(); tick();
        check("t5b_done_cnt", done_cnt - d0, 1);
        check("t5b_sb_empty", sb.size(), 0);
        check("t5b_phase_final", phaseInc, 32'h00002000);

        // zero-point sweep
        startInc = 32'hDEADBEEF; numPoints = 0;
        start = 1'b1;
        tick();
        start = 1'b0;
        @(negedge CLK);
        check("t6_zero_done", done, 1);
        check("t6_zero_busy", busy, 0);
        check("t6_zero_phase", phaseInc, 32'h00002000);
        tick();
        @(negedge CLK);
        check("t6_zero_done_pulse", done, 0);

        // start and abort together in IDLE
        tick();
        numPoints = 2; start = 1'b1; abort = 1'b1;
        tick();
        start = 1'b0; abort = 1'b0;
        @(negedge CLK);
        check("t6_abort_wins_busy", busy, 0);
        check("t6_abort_wins_done", done, 0);

        // reset in the middle of SETTLE
        tick();
        ci = 14'sd9; cq = 14'sd9;
        go(32'h11110000, 32'h00000001, 2, 20, 0, 14'sd0, 14'sd0, 0);
        repeat (3) tick();
        check("t7_busy_before", busy, 1);
        reset = 1'b1;
        tick();
        reset = 1'b0;
        @(negedge CLK);
        check_reset_outputs("t7_rst");
        sb.delete();

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule

// File: doc/iq_sweep_controller.md
Name: iq_sweep_controller

Overview:
- Sequencer that steps the NCO phase increment of the IQ demodulator through a programmed frequency sweep.
- At each sweep point it waits a settling interval for the mixer/FIR pipeline to flush, averages 2^avgLog2 filter-valid I/Q samples, and presents one result word per point on a valid/ready stream.
- Sits between the host/control logic and the IQ demodulator: drives its phaseInc input and consumes its I, Q and filter-valid outputs.

Parameters:
- PHASE_W, 32, phase-increment width (NCO tuning word)
- IQ_W, 14, signed I/Q sample width
- NPTS_W, 12, sweep point count/index width
- SETTLE_W, 16, settle-counter width
- AVG_MAX, 8, maximum avgLog2 honoured; larger values clamp to AVG_MAX

Ports:
- CLK  in  1  single system clock; all logic rising-edge
- reset  in  1  synchronous, active-high reset
- start  in  1  one-cycle sweep request; honoured only in IDLE
- abort  in  1  terminate sweep; return to IDLE
- startInc  in  PHASE_W  first-point phase increment, latched on start
- stepInc  in  PHASE_W  per-point increment step, latched on start, modulo 2^PHASE_W
- numPoints  in  NPTS_W  points in sweep, latched on start
- settleCycles  in  SETTLE_W  settle wait per point, latched on start
- avgLog2  in  4  log2 of samples averaged per point, latched on start
- filtValid  in  1  demodulator I/Q valid strobe
- I  in  IQ_W  signed demodulated in-phase sample
- Q  in  IQ_W  signed demodulated quadrature sample
- phaseInc  out  PHASE_W  tuning word to the NCO
- busy  out  1  high in any state other than IDLE
- done  out  1  one-cycle pulse when a sweep completes normally
- out_valid  out  1  result word available
- out_ready  in  1  consumer accepts result
- out_index  out  NPTS_W  sweep point index of the result
- out_I  out  IQ_W  averaged I
- out_Q  out  IQ_W  averaged Q

Behaviour:
- Reset: state IDLE; phaseInc=0, busy=0, done=0, out_valid=0, out_index=0, out_I=0, out_Q=0; accumulators, counters and latched config cleared. Reset overrides start/abort and takes effect mid-sweep.
- States: IDLE, SETTLE, ACCUM, EMIT.
- IDLE, start=1 at cycle t:
  - latch config; index=0.
  - If numPoints=0: done=1 at t+1, remain IDLE, phaseInc unchanged.
  - Otherwise: at t+1 phaseInc=startInc, state SETTLE, settle counter loaded with settleCycles.
- SETTLE:
  - Counter decrements each cycle; filtValid is ignored.
  - At zero, go to ACCUM. settleCycles=0 means exactly one SETTLE cycle.
- ACCUM:
  - Each cycle with filtValid=1, add sign-extended I and Q into accumulators of width IQ_W+AVG_MAX and increment the sample count.
  - Cycles with filtValid=0 do nothing.
  - When the count reaches 2^min(avgLog2,AVG_MAX), go to EMIT.
- EMIT:
  - On entry, out_I/out_Q = accumulator arithmetic-shifted right by the effective avgLog2 (floor rounding), truncated to IQ_W; out_index=index; out_valid=1.
  - out_valid, out_I, out_Q and out_index hold stable until the cycle with out_valid&out_ready.
  - On that handshake:
    - Last point (index=numPoints-1): done=1 next cycle, out_valid=0, IDLE; phaseInc holds its final value.
    - Otherwise: index+1, phaseInc+=stepInc (wrap mod 2^PHASE_W), accumulators cleared, SETTLE reloaded, out_valid=0.
- Back-pressure: the next point's settle does not start until the current result is accepted.
- start while busy is ignored.
- abort=1 in any non-IDLE state: next cycle IDLE, out_valid=0, done=0, phaseInc holds. abort has priority over a same-cycle handshake.
- start and abort in the same cycle in IDLE: abort wins, start ignored.

Decomposition:
- Shared package iq_ctrl_pkg: state enum, PHASE_W/IQ_W/NPTS_W defaults, AVG_MAX, ACC_W=IQ_W+AVG_MAX.
- One natural sub-module, iq_accumulator: I/Q accumulate, sample count, shift-average output, clear input. The controller FSM, phase stepping and output register stay in the top.

Test Plan:
- numPoints=3, startInc=0x01000000, stepInc=0x00100000, settle=4, avgLog2=0, I=100, Q=-50 constant, filtValid=1, out_ready=1
  - phaseInc takes 0x01000000, 0x01100000, 0x01200000.
  - Three results, indices 0..2, each I=100, Q=-50.
  - done pulse one cycle after the third handshake.
- avgLog2=2, filtValid only every 3rd cycle, I sequence 1,2,3,6
  - out_I=3 after exactly 4 valid samples.
  - Q sequence -1,-1,-1,-2 gives out_Q=-2 (floor).
- out_ready low for 20 cycles in EMIT
  - out_valid and data held stable throughout; phaseInc unchanged.
  - Next point starts only after ready rises.
- startInc=0xFFF00000, stepInc=0x00200000, numPoints=2 -> second phaseInc=0x00100000 (wrap).
- abort during ACCUM of point 1 -> next cycle busy=0, out_valid=0, no done; a new start then runs a full sweep correctly.
- numPoints=0 with start -> done pulse at t+1, busy stays 0. Also: reset asserted mid-SETTLE -> all outputs at reset values next cycle.
